// File: rtl/cmp_pkg.sv
// Shared types and constants for the data-flow magnitude comparator.
// The result is a one-hot {e,g,l} triple; all-zero means "no result yet".
package cmp_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic e;
    logic g;
    logic l;
  } cmp_res_t;

  localparam cmp_res_t RES_EQ   = 3'b100;
  localparam cmp_res_t RES_GT   = 3'b010;
  localparam cmp_res_t RES_LT   = 3'b001;
  localparam cmp_res_t RES_NONE = 3'b000;

  // A settled result has exactly one flag set.
  function automatic logic res_is_one_hot(input cmp_res_t r);
    return (r == RES_EQ) || (r == RES_GT) || (r == RES_LT);
  endfunction

endpackage

// File: rtl/comparator_4bit_df_if.sv
// Operand/result bundle for the comparator.
// The master drives the operands and the slave returns the registered flags.
interface comparator_4bit_df_if #(
  parameter int WIDTH = cmp_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e;
  logic             g;
  logic             l;

  modport master (output a, output b, input e, input g, input l);
  modport slave  (input a, input b, output e, output g, output l);
endinterface

// File: rtl/comparator_4bit_df_slice.sv
// One bit position of the comparator chain.
// A bit can only decide the result while every higher bit is equal.
module cmp_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic eq_in,
  output logic eq_out,
  output logic gt_i,
  output logic lt_i
);

  logic x_s;

  assign x_s    = ~(a_i ^ b_i);
  assign eq_out = eq_in & x_s;
  assign gt_i   = eq_in & a_i & ~b_i;
  assign lt_i   = eq_in & ~a_i & b_i;

endmodule

// File: rtl/comparator_4bit_df.sv
// Unsigned magnitude comparator: a ripple of slices from MSB to LSB feeding
// one async-reset result register, giving one cycle of latency.
module comparator_4bit_df
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic             e,
  output logic             g,
  output logic             l,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  // eq_chain[i+1] is "all bits above i are equal"; the top seed is always true.
  logic [WIDTH:0]   eq_chain;
  logic [WIDTH-1:0] gt_vec;
  logic [WIDTH-1:0] lt_vec;
  logic             e_c;
  logic             g_c;
  logic             l_c;
  cmp_res_t         res_d;
  cmp_res_t         res_q;

  assign eq_chain[WIDTH] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    cmp_slice u_slice (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .eq_in  (eq_chain[i+1]),
      .eq_out (eq_chain[i]),
      .gt_i   (gt_vec[i]),
      .lt_i   (lt_vec[i])
    );
  end

  assign e_c   = eq_chain[0];
  assign g_c   = |gt_vec;
  assign l_c   = |lt_vec;
  assign res_d = '{e: e_c, g: g_c, l: l_c};

  // Result register; reset forces the "no result" state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= RES_NONE;
    end else begin
      res_q <= res_d;
    end
  end

  assign e = res_q.e;
  assign g = res_q.g;
  assign l = res_q.l;

endmodule

// File: tb/tb_comparator_4bit_df.sv
// Directed and exhaustive checks of the registered comparator flags,
// including async reset, latency and the one-hot invariant.
module tb_comparator_4bit_df;
  import cmp_pkg::*;

  logic clk;
  logic rst;
  logic onehot_en;
  int   checks;
  int   errors;

  comparator_4bit_df_if #(.WIDTH(4)) bus ();

  comparator_4bit_df #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .e   (bus.e),
    .g   (bus.g),
    .l   (bus.l),
    .a   (bus.a),
    .b   (bus.b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [3:0] ra, input logic [3:0] rb);
    if (ra == rb)     return RES_EQ;
    else if (ra > rb) return RES_GT;
    else              return RES_LT;
  endfunction

  // Apply operands now (just after a falling edge) and land after the next falling edge.
  task automatic step(input logic [3:0] na, input logic [3:0] nb);
    bus.a = na;
    bus.b = nb;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] flags();
    return {bus.e, bus.g, bus.l};
  endfunction

  // Exactly one flag set on every cycle once a post-reset edge has occurred.
  always @(negedge clk) begin
    if (onehot_en) begin
      check_eq("onehot", {2'b00, bus.e} + {2'b00, bus.g} + {2'b00, bus.l}, 3'd1);
    end
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    onehot_en = 1'b0;
    checks    = 0;
    errors    = 0;
    bus.a     = 4'h0;
    bus.b     = 4'h0;

    #3;
    check_eq("reset_state", flags(), 3'b000);
    @(negedge clk);
    check_eq("reset_held_over_edge", flags(), 3'b000);
    rst = 1'b0;

    // Boundaries
    step(4'h0, 4'h0); check_eq("zero_zero", flags(), 3'b100);
    onehot_en = 1'b1;
    step(4'hF, 4'h0); check_eq("f_zero", flags(), 3'b010);
    step(4'h0, 4'hF); check_eq("zero_f", flags(), 3'b001);
    step(4'hF, 4'hF); check_eq("f_f", flags(), 3'b100);

    // MSB dominance
    step(4'h8, 4'h7); check_eq("msb_8_7", flags(), 3'b010);
    step(4'h7, 4'h8); check_eq("msb_7_8", flags(), 3'b001);
    step(4'h1, 4'h0); check_eq("lsb_1_0", flags(), 3'b010);
    step(4'h6, 4'h5); check_eq("lsb_6_5", flags(), 3'b010);
    step(4'hA, 4'hB); check_eq("lsb_a_b", flags(), 3'b001);

    // Equality diagonal
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 4'(i));
      check_eq("diag", flags(), 3'b100);
    end

    // Latency: l holds until the edge, g appears right after it
    step(4'h2, 4'h5); check_eq("lat_lt", flags(), 3'b001);
    bus.a = 4'h5;
    bus.b = 4'h2;
    #1;
    check_eq("lat_before_edge", flags(), 3'b001);
    @(posedge clk);
    #1;
    check_eq("lat_after_edge", flags(), 3'b010);
    @(negedge clk);

    // Exhaustive sweep with a reset dropped in mid-way
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      if (v == 128) begin
        step(4'h9, 4'h3);
        check_eq("pre_reset_gt", flags(), 3'b010);
        #2;
        onehot_en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_reset", flags(), 3'b000);
        @(negedge clk);
        check_eq("reset_hold", flags(), 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_reset_gt", flags(), 3'b010);
        @(negedge clk);
        onehot_en = 1'b1;
      end
      step(vv[7:4], vv[3:0]);
      check_eq("sweep", flags(), ref_res(vv[7:4], vv[3:0]));
    end

    onehot_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
